// File: rtl/tx_key_sequencer.sv
// rtl/tx_key_sequencer.sv - T/R key sequencer: key debounce, PTT lead/hang, carrier gating, runaway lockout
module tx_key_sequencer #(
  parameter int CTR_W        = 32,
  parameter int DEBOUNCE_CYC = 270000,
  parameter int LEAD_CYC     = 27000,
  parameter int HANG_CYC     = 2700000,
  parameter int TIMEOUT_CYC  = 270000000,
  parameter int BLINK_BIT    = 22
) (
  input  logic clk_27MHz,
  input  logic rst_n,
  input  logic key,
  output logic ptt,
  output logic tx_en,
  output logic timeout_flag,
  output logic key_led,
  output logic status_led
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_KEYED,
    ST_HANG,
    ST_LOCKOUT
  } state_e;

  localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX   = '1;
  localparam logic [CTR_W-1:0] DB_LAST   = CTR_W'(DEBOUNCE_CYC - 1);
  localparam logic [CTR_W-1:0] LEAD_LAST = CTR_W'(LEAD_CYC - 1);
  localparam logic [CTR_W-1:0] HANG_LAST = CTR_W'(HANG_CYC - 1);
  localparam logic [CTR_W-1:0] TO_LAST   = CTR_W'(TIMEOUT_CYC - 1);

  // Reset asserts asynchronously everywhere but releases only on a clock edge.
  logic rst_meta_q, rst_sync_n_q;

  always_ff @(posedge clk_27MHz or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q   <= 1'b0;
      rst_sync_n_q <= 1'b0;
    end else begin
      rst_meta_q   <= 1'b1;
      rst_sync_n_q <= rst_meta_q;
    end
  end

  logic             key_meta_q, key_s_q;
  logic             key_db_q, key_db_d;
  logic [CTR_W-1:0] db_cnt_q, db_cnt_d;
  state_e           state_q, state_d;
  logic [CTR_W-1:0] phase_q, phase_d;
  logic [CTR_W-1:0] blink_q, blink_d;
  logic             ptt_q, ptt_d;
  logic             tx_en_q, tx_en_d;
  logic             tflag_q, tflag_d;
  logic             status_q, status_d;
  logic             pressed;

  assign pressed = ~key_db_q;

  always_comb begin
    db_cnt_d = '0;
    key_db_d = key_db_q;
    if (key_s_q != key_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_db_d = key_s_q;
      end else begin
        db_cnt_d = db_cnt_q + CTR_ONE;
      end
    end
  end

  // One phase counter serves as lead, key-down and hang timer; it restarts on every state change.
  always_comb begin
    state_d = state_q;
    phase_d = (phase_q == CTR_MAX) ? phase_q : phase_q + CTR_ONE;
    blink_d = blink_q + CTR_ONE;
    unique case (state_q)
      ST_IDLE: begin
        if (pressed) state_d = ST_LEAD;
      end
      ST_LEAD: begin
        if (!pressed)                   state_d = ST_HANG;
        else if (phase_q == LEAD_LAST)  state_d = ST_KEYED;
      end
      ST_KEYED: begin
        if (phase_q == TO_LAST)         state_d = ST_LOCKOUT;
        else if (!pressed)              state_d = ST_HANG;
      end
      ST_HANG: begin
        if (pressed)                    state_d = ST_KEYED;
        else if (phase_q == HANG_LAST)  state_d = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (!pressed) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) phase_d = '0;

    ptt_d    = (state_d == ST_LEAD) || (state_d == ST_KEYED) || (state_d == ST_HANG);
    tx_en_d  = (state_d == ST_KEYED);
    tflag_d  = (state_d == ST_LOCKOUT);
    status_d = 1'b1;
    if (state_d == ST_IDLE)    status_d = blink_d[BLINK_BIT];
    if (state_d == ST_LOCKOUT) status_d = blink_d[BLINK_BIT-2];
  end

  always_ff @(posedge clk_27MHz or negedge rst_sync_n_q) begin
    if (!rst_sync_n_q) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      key_db_q   <= 1'b1;
      db_cnt_q   <= '0;
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      blink_q    <= '0;
      ptt_q      <= 1'b0;
      tx_en_q    <= 1'b0;
      tflag_q    <= 1'b0;
      status_q   <= 1'b0;
    end else begin
      key_meta_q <= key;
      key_s_q    <= key_meta_q;
      key_db_q   <= key_db_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      blink_q    <= blink_d;
      ptt_q      <= ptt_d;
      tx_en_q    <= tx_en_d;
      tflag_q    <= tflag_d;
      status_q   <= status_d;
    end
  end

  assign ptt          = ptt_q;
  assign tx_en        = tx_en_q;
  assign timeout_flag = tflag_q;
  assign key_led      = key_db_q;
  assign status_led   = status_q;

endmodule

// File: tb/tb_tx_key_sequencer.sv
// tb/tb_tx_key_sequencer.sv - scoreboard bench for tx_key_sequencer output transition timing
module tb_tx_key_sequencer;

  logic clk = 1'b0;
  logic rst_n, key;
  logic ptt, tx_en, timeout_flag, key_led, status_led;

  tx_key_sequencer #(
    .CTR_W(32), .DEBOUNCE_CYC(4), .LEAD_CYC(3), .HANG_CYC(5),
    .TIMEOUT_CYC(20), .BLINK_BIT(4)
  ) dut (
    .clk_27MHz(clk), .rst_n(rst_n), .key(key), .ptt(ptt), .tx_en(tx_en),
    .timeout_flag(timeout_flag), .key_led(key_led), .status_led(status_led)
  );

  always #5 clk = ~clk;

  // Event signature: {timeout_flag, ptt, tx_en, key_led}, stamped with the negedge index.
  typedef struct {
    int         cyc;
    logic [3:0] sig;
  } ev_t;

  ev_t        exp_q[$];
  int         ncyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [3:0] prev;

  always @(negedge clk) begin
    logic [3:0] sig;
    ev_t e;
    ncyc = ncyc + 1;
    sig = {timeout_flag, ptt, tx_en, key_led};
    if (mon_en) begin
      checks++;
      if (tx_en && !ptt) begin
        errors++;
        $display("FAIL tx_without_ptt: cyc %0d tx_en=%b ptt=%b, want ptt=1", ncyc, tx_en, ptt);
      end
      if (sig !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cyc %0d sig=%b, want no change from %b", ncyc, sig, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != ncyc || e.sig !== sig) begin
            errors++;
            $display("FAIL transition: got cyc %0d sig=%b, want cyc %0d sig=%b", ncyc, sig, e.cyc, e.sig);
          end
        end
      end
    end
    prev = sig;
  end

  task automatic step_to(input int n);
    while (ncyc < n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    step_to(ncyc + n);
  endtask

  task automatic expect_ev(input int c, input logic [3:0] s);
    exp_q.push_back(ev_t'{c, s});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key   = 1'b1;
    idle(3);
    checks += 5;
    if (ptt !== 1'b0)          begin errors++; $display("FAIL reset_ptt: got %b want 0", ptt); end
    if (tx_en !== 1'b0)        begin errors++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
    if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_flag); end
    if (key_led !== 1'b1)      begin errors++; $display("FAIL reset_key_led: got %b want 1", key_led); end
    if (status_led !== 1'b0)   begin errors++; $display("FAIL reset_status: got %b want 0", status_led); end
    rst_n = 1'b1;
    idle(8);
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_press_release();
    int k, r;
    idle(3);
    k = ncyc; key = 1'b0;
    expect_ev(k + 6, 4'b0000);
    expect_ev(k + 7, 4'b0100);
    expect_ev(k + 10, 4'b0110);
    step_to(k + 12);
    checks++;
    if (status_led !== 1'b1) begin errors++; $display("FAIL keyed_status: got %b want 1", status_led); end
    step_to(k + 15);
    r = ncyc; key = 1'b1;
    expect_ev(r + 6, 4'b0111);
    expect_ev(r + 7, 4'b0101);
    expect_ev(r + 12, 4'b0001);
    step_to(r + 20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL press_release_pending: got %0d left want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    int k;
    idle(3);
    k = ncyc; key = 1'b0;
    step_to(k + 3);
    key = 1'b1;
    step_to(k + 20);
    checks += 3;
    if (key_led !== 1'b1) begin errors++; $display("FAIL glitch_key_led: got %b want 1", key_led); end
    if (ptt !== 1'b0)     begin errors++; $display("FAIL glitch_ptt: got %b want 0", ptt); end
    if (tx_en !== 1'b0)   begin errors++; $display("FAIL glitch_tx_en: got %b want 0", tx_en); end
  endtask

  task automatic test_min_press();
    int k;
    idle(3);
    k = ncyc; key = 1'b0;
    expect_ev(k + 6, 4'b0000);
    expect_ev(k + 7, 4'b0100);
    step_to(k + 4);
    key = 1'b1;
    expect_ev(k + 10, 4'b0111);
    expect_ev(k + 11, 4'b0101);
    expect_ev(k + 16, 4'b0001);
    step_to(k + 24);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL min_press_pending: got %0d left want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_rekey();
    int k, r, p, s;
    for (int gap = 4; gap <= 5; gap++) begin
      idle(3);
      k = ncyc; key = 1'b0;
      expect_ev(k + 6, 4'b0000);
      expect_ev(k + 7, 4'b0100);
      expect_ev(k + 10, 4'b0110);
      step_to(k + 8);
      r = ncyc; key = 1'b1;
      expect_ev(r + 6, 4'b0111);
      expect_ev(r + 7, 4'b0101);
      step_to(r + gap);
      p = ncyc; key = 1'b0;
      expect_ev(p + 6, 4'b0100);
      expect_ev(p + 7, 4'b0110);
      step_to(p + 6);
      s = ncyc; key = 1'b1;
      expect_ev(s + 6, 4'b0111);
      expect_ev(s + 7, 4'b0101);
      expect_ev(s + 12, 4'b0001);
      step_to(s + 16);
      checks++;
      if (exp_q.size() != 0) begin
        errors++; $display("FAIL rekey_gap%0d_pending: got %0d left want 0", gap, exp_q.size()); exp_q.delete();
      end
    end
  endtask

  task automatic test_timeout();
    int k, r, q;
    bit seen0, seen1;
    idle(3);
    k = ncyc; key = 1'b0;
    expect_ev(k + 6, 4'b0000);
    expect_ev(k + 7, 4'b0100);
    expect_ev(k + 10, 4'b0110);
    expect_ev(k + 30, 4'b1000);
    step_to(k + 30);
    seen0 = 1'b0; seen1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (status_led === 1'b0) seen0 = 1'b1;
      if (status_led === 1'b1) seen1 = 1'b1;
    end
    checks += 2;
    if (!(seen0 && seen1)) begin errors++; $display("FAIL lockout_blink: got seen0=%b seen1=%b want 1 1", seen0, seen1); end
    if (timeout_flag !== 1'b1) begin errors++; $display("FAIL lockout_flag: got %b want 1", timeout_flag); end
    step_to(k + 40);
    r = ncyc; key = 1'b1;
    expect_ev(r + 6, 4'b1001);
    expect_ev(r + 7, 4'b0001);
    step_to(r + 12);
    q = ncyc; key = 1'b0;
    expect_ev(q + 6, 4'b0000);
    expect_ev(q + 7, 4'b0100);
    expect_ev(q + 10, 4'b0110);
    step_to(q + 5);
    key = 1'b1;
    expect_ev(q + 11, 4'b0111);
    expect_ev(q + 12, 4'b0101);
    expect_ev(q + 17, 4'b0001);
    step_to(q + 24);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL timeout_pending: got %0d left want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_async_reset();
    int k;
    idle(3);
    k = ncyc; key = 1'b0;
    expect_ev(k + 6, 4'b0000);
    expect_ev(k + 7, 4'b0100);
    expect_ev(k + 10, 4'b0110);
    step_to(k + 12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pre_reset_pending: got %0d left want 0", exp_q.size()); exp_q.delete();
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (ptt !== 1'b0)          begin errors++; $display("FAIL async_rst_ptt: got %b want 0", ptt); end
    if (tx_en !== 1'b0)        begin errors++; $display("FAIL async_rst_tx_en: got %b want 0", tx_en); end
    if (timeout_flag !== 1'b0) begin errors++; $display("FAIL async_rst_timeout: got %b want 0", timeout_flag); end
    key = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(8);
    exp_q.delete();
    mon_en = 1'b1;
    k = ncyc; key = 1'b0;
    expect_ev(k + 6, 4'b0000);
    expect_ev(k + 7, 4'b0100);
    expect_ev(k + 10, 4'b0110);
    step_to(k + 8);
    key = 1'b1;
    expect_ev(k + 14, 4'b0111);
    expect_ev(k + 15, 4'b0101);
    expect_ev(k + 20, 4'b0001);
    step_to(k + 26);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL post_reset_pending: got %0d left want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_min_press();
    test_rekey();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
